// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised FIFO family: default sizes and the
// width helper used to size pointers and occupancy counters.
package fifo_pkg;

  localparam int FIFO_DEPTH_DEFAULT = 4;
  localparam int FIFO_WIDTH_DEFAULT = 704;

  // Ceiling log2 of a positive value, written with a bounded loop so it
  // elaborates as a constant function in every tool.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Ring pointer that counts 0..DEPTH-1 and wraps back to zero, so the FIFO
// works for any depth and not only for powers of two.
module fifo_ptr_wrap
  import fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int PW    = clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          clear_i,
  input  logic          advance_i,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Next pointer: clear wins over advance; the last slot wraps to zero.
  always_comb begin
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (advance_i) begin
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  // Pointer register, zeroed asynchronously by reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_n_oc.sv
// N-entry FIFO with enq/deq/first method handshakes, occupancy count,
// almost-full flag, synchronous flush and an optional pipeline mode in
// which a full FIFO still accepts an enqueue when a dequeue fires alongside.
module fifo_n_oc
  import fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_WIDTH_DEFAULT,
  parameter int DEPTH    = FIFO_DEPTH_DEFAULT,
  parameter int AFULL    = 3,
  parameter int PIPELINE = 0
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        in_enq__ENA,
  input  logic [WIDTH-1:0]            in_enq_v,
  output logic                        in_enq__RDY,
  input  logic                        out_deq__ENA,
  output logic                        out_deq__RDY,
  output logic [WIDTH-1:0]            out_first,
  output logic                        out_first__RDY,
  input  logic                        flush,
  output logic [clog2(DEPTH+1)-1:0]   count,
  output logic                        almost_full
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [PW-1:0]    rdPtr;
  logic [PW-1:0]    wrPtr;
  logic             notEmpty;
  logic             enqFire;
  logic             deqFire;

  assign notEmpty = (count_q != '0);

  // The pipeline path only looks at the dequeue side, so enqueue ENA never
  // loops back into enqueue RDY.
  assign in_enq__RDY    = (count_q != CW'(DEPTH)) |
                          ((PIPELINE != 0) & out_deq__ENA & notEmpty);
  assign out_deq__RDY   = notEmpty;
  assign out_first__RDY = notEmpty;
  assign out_first      = notEmpty ? mem_q[rdPtr] : '0;
  assign count          = count_q;
  assign almost_full    = (count_q >= CW'(AFULL));

  // Flush overrides both methods, so neither strobe takes effect that cycle.
  assign enqFire = in_enq__ENA & in_enq__RDY & ~flush;
  assign deqFire = out_deq__ENA & notEmpty & ~flush;

  fifo_ptr_wrap #(.DEPTH(DEPTH), .PW(PW)) uRdPtr (
    .CLK       (CLK),
    .nRST      (nRST),
    .clear_i   (flush),
    .advance_i (deqFire),
    .ptr_o     (rdPtr)
  );

  fifo_ptr_wrap #(.DEPTH(DEPTH), .PW(PW)) uWrPtr (
    .CLK       (CLK),
    .nRST      (nRST),
    .clear_i   (flush),
    .advance_i (enqFire),
    .ptr_o     (wrPtr)
  );

  // Occupancy moves only when exactly one of enq/deq fires.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (enqFire && !deqFire) begin
      count_d = count_q + CW'(1);
    end else if (deqFire && !enqFire) begin
      count_d = count_q - CW'(1);
    end
  end

  // Occupancy register, cleared asynchronously by reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Payload storage is not reset; the count keeps stale slots invisible.
  always_ff @(posedge CLK) begin
    if (enqFire) begin
      mem_q[wrPtr] <= in_enq_v;
    end
  end

endmodule

// File: tb/tb_fifo_n_oc.sv
// Scoreboard bench for fifo_n_oc: three instances cover depth 4, the
// non-power-of-two depth 3 and the pipeline mode. Accepted enqueues push
// their payload into a per-instance queue; a monitor pops and compares
// whenever a dequeue is about to fire.
module tb_fifo_n_oc;

  logic        clk;
  logic        nRST;
  logic [2:0]  enqEna;
  logic [31:0] enqV [3];
  logic [2:0]  enqRdy;
  logic [2:0]  deqEna;
  logic [2:0]  deqRdy;
  logic [31:0] firstOut [3];
  logic [2:0]  firstRdy;
  logic [2:0]  flushIn;
  logic [2:0]  afull;
  logic [2:0]  count0;
  logic [1:0]  count1;
  logic [2:0]  count2;

  logic [31:0] expQ0 [$];
  logic [31:0] expQ1 [$];
  logic [31:0] expQ2 [$];

  int total = 0;
  int bad   = 0;

  fifo_n_oc #(.WIDTH(32), .DEPTH(4), .AFULL(3), .PIPELINE(0)) uFifo0 (
    .CLK(clk), .nRST(nRST),
    .in_enq__ENA(enqEna[0]), .in_enq_v(enqV[0]), .in_enq__RDY(enqRdy[0]),
    .out_deq__ENA(deqEna[0]), .out_deq__RDY(deqRdy[0]),
    .out_first(firstOut[0]), .out_first__RDY(firstRdy[0]),
    .flush(flushIn[0]), .count(count0), .almost_full(afull[0])
  );

  fifo_n_oc #(.WIDTH(32), .DEPTH(3), .AFULL(2), .PIPELINE(0)) uFifo1 (
    .CLK(clk), .nRST(nRST),
    .in_enq__ENA(enqEna[1]), .in_enq_v(enqV[1]), .in_enq__RDY(enqRdy[1]),
    .out_deq__ENA(deqEna[1]), .out_deq__RDY(deqRdy[1]),
    .out_first(firstOut[1]), .out_first__RDY(firstRdy[1]),
    .flush(flushIn[1]), .count(count1), .almost_full(afull[1])
  );

  fifo_n_oc #(.WIDTH(32), .DEPTH(4), .AFULL(3), .PIPELINE(1)) uFifo2 (
    .CLK(clk), .nRST(nRST),
    .in_enq__ENA(enqEna[2]), .in_enq_v(enqV[2]), .in_enq__RDY(enqRdy[2]),
    .out_deq__ENA(deqEna[2]), .out_deq__RDY(deqRdy[2]),
    .out_first(firstOut[2]), .out_first__RDY(firstRdy[2]),
    .flush(flushIn[2]), .count(count2), .almost_full(afull[2])
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and tally the result.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Record the payload an accepted enqueue should later deliver.
  task automatic pushExp(input int idx, input logic [31:0] v);
    case (idx)
      0: expQ0.push_back(v);
      1: expQ1.push_back(v);
      default: expQ2.push_back(v);
    endcase
  endtask

  // Pop the oldest expected payload for an instance and compare the head.
  task automatic popCheck(input int idx, input logic [31:0] actual);
    logic [31:0] expected;
    int size;
    case (idx)
      0: size = expQ0.size();
      1: size = expQ1.size();
      default: size = expQ2.size();
    endcase
    if (size == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard%0d underflow: got 0x%0h expected no dequeue", idx, actual);
    end else begin
      case (idx)
        0: expected = expQ0.pop_front();
        1: expected = expQ1.pop_front();
        default: expected = expQ2.pop_front();
      endcase
      checkOutput($sformatf("first%0d", idx), 64'(actual), 64'(expected));
    end
  endtask

  function automatic int getCount(input int idx);
    case (idx)
      0: return int'(count0);
      1: return int'(count1);
      default: return int'(count2);
    endcase
  endfunction

  // Drive one cycle of stimulus on one instance, starting just after a
  // rising edge and returning just after the next one.
  task automatic applyStimulus(input int idx, input bit enq, input logic [31:0] v,
                               input bit deq, input bit fl, input bit accept);
    enqEna[idx]  = enq;
    enqV[idx]    = v;
    deqEna[idx]  = deq;
    flushIn[idx] = fl;
    if (accept) pushExp(idx, v);
    @(posedge clk);
    #1;
    enqEna[idx]  = 1'b0;
    deqEna[idx]  = 1'b0;
    flushIn[idx] = 1'b0;
  endtask

  // Monitor: on the falling edge, any dequeue about to fire consumes the
  // oldest expected payload; occupancy must also stay within depth.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (deqEna[i] && deqRdy[i]) popCheck(i, firstOut[i]);
    end
    checkOutput("count0 bound", 64'(getCount(0) <= 4), 64'(1));
    checkOutput("count1 bound", 64'(getCount(1) <= 3), 64'(1));
  end

  // Runaway guard.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nRST    = 1'b0;
    enqEna  = '0;
    deqEna  = '0;
    flushIn = '0;
    for (int i = 0; i < 3; i++) enqV[i] = '0;

    // Reset held: strobes toggle but nothing may be stored.
    @(posedge clk); #1;
    enqEna[0] = 1'b1; enqV[0] = 32'hDEAD; deqEna[0] = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst count0", 64'(getCount(0)), 64'(0));
    checkOutput("rst enqRdy0", 64'(enqRdy[0]), 64'(1));
    checkOutput("rst deqRdy0", 64'(deqRdy[0]), 64'(0));
    checkOutput("rst firstRdy0", 64'(firstRdy[0]), 64'(0));
    checkOutput("rst first0", 64'(firstOut[0]), 64'(0));
    checkOutput("rst afull0", 64'(afull[0]), 64'(0));
    enqEna[0] = 1'b0; deqEna[0] = 1'b0;
    nRST = 1'b1;
    @(posedge clk); #1;
    checkOutput("post-rst count0", 64'(getCount(0)), 64'(0));
    checkOutput("post-rst deqRdy0", 64'(deqRdy[0]), 64'(0));

    // Fill and drain the depth-4 FIFO.
    applyStimulus(0, 1, 32'h11, 0, 0, 1);
    checkOutput("fill count 1", 64'(getCount(0)), 64'(1));
    applyStimulus(0, 1, 32'h22, 0, 0, 1);
    checkOutput("fill afull at 2", 64'(afull[0]), 64'(0));
    applyStimulus(0, 1, 32'h33, 0, 0, 1);
    checkOutput("fill afull at 3", 64'(afull[0]), 64'(1));
    applyStimulus(0, 1, 32'h44, 0, 0, 1);
    checkOutput("fill count 4", 64'(getCount(0)), 64'(4));
    checkOutput("full enqRdy0", 64'(enqRdy[0]), 64'(0));
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 32'h0, 1, 0, 0);
      checkOutput("drain count", 64'(getCount(0)), 64'(3 - k));
    end
    checkOutput("drained deqRdy0", 64'(deqRdy[0]), 64'(0));

    // Depth 3: alternating enq/deq of 1..10 wraps both pointers.
    for (int v = 1; v <= 10; v++) begin
      applyStimulus(1, 1, 32'(v), 0, 0, 1);
      checkOutput("wrap count after enq", 64'(getCount(1)), 64'(1));
      applyStimulus(1, 0, 32'h0, 1, 0, 0);
      checkOutput("wrap count after deq", 64'(getCount(1)), 64'(0));
    end
    applyStimulus(1, 1, 32'h71, 0, 0, 1);
    applyStimulus(1, 1, 32'h72, 0, 0, 1);
    checkOutput("d3 afull at 2", 64'(afull[1]), 64'(1));
    applyStimulus(1, 1, 32'h73, 0, 0, 1);
    checkOutput("d3 full enqRdy", 64'(enqRdy[1]), 64'(0));
    checkOutput("d3 full count", 64'(getCount(1)), 64'(3));
    for (int k = 0; k < 3; k++) applyStimulus(1, 0, 32'h0, 1, 0, 0);
    checkOutput("d3 drained count", 64'(getCount(1)), 64'(0));

    // Full with simultaneous enq/deq, non-pipelined: only the deq fires.
    for (int k = 1; k <= 4; k++) applyStimulus(0, 1, 32'hA0 + 32'(k), 0, 0, 1);
    deqEna[0] = 1'b1; #1;
    checkOutput("nopipe full enqRdy", 64'(enqRdy[0]), 64'(0));
    deqEna[0] = 1'b0;
    applyStimulus(0, 1, 32'hBB, 1, 0, 0);
    checkOutput("nopipe count", 64'(getCount(0)), 64'(3));
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 32'h0, 1, 0, 0);
    checkOutput("nopipe drained", 64'(getCount(0)), 64'(0));

    // Same stimulus with pipeline mode: both fire, new value lands at tail.
    for (int k = 1; k <= 4; k++) applyStimulus(2, 1, 32'hA0 + 32'(k), 0, 0, 1);
    deqEna[2] = 1'b1; #1;
    checkOutput("pipe full enqRdy", 64'(enqRdy[2]), 64'(1));
    deqEna[2] = 1'b0;
    applyStimulus(2, 1, 32'hCC, 1, 0, 1);
    checkOutput("pipe count", 64'(getCount(2)), 64'(4));
    for (int k = 0; k < 4; k++) applyStimulus(2, 0, 32'h0, 1, 0, 0);
    checkOutput("pipe drained", 64'(getCount(2)), 64'(0));

    // Flush with an enqueue in the same cycle drops everything.
    applyStimulus(0, 1, 32'h51, 0, 0, 1);
    applyStimulus(0, 1, 32'h52, 0, 0, 1);
    checkOutput("preflush count", 64'(getCount(0)), 64'(2));
    expQ0.delete();
    applyStimulus(0, 1, 32'h53, 0, 1, 0);
    checkOutput("flush count", 64'(getCount(0)), 64'(0));
    checkOutput("flush deqRdy", 64'(deqRdy[0]), 64'(0));
    checkOutput("flush first", 64'(firstOut[0]), 64'(0));
    applyStimulus(0, 1, 32'h54, 0, 0, 1);
    applyStimulus(0, 0, 32'h0, 1, 0, 0);
    checkOutput("postflush count", 64'(getCount(0)), 64'(0));

    // Asynchronous reset in the middle of a burst.
    applyStimulus(0, 1, 32'h61, 0, 0, 1);
    applyStimulus(0, 1, 32'h62, 0, 0, 1);
    checkOutput("midburst count", 64'(getCount(0)), 64'(2));
    enqEna[0] = 1'b1; enqV[0] = 32'h63;
    #2;
    nRST = 1'b0;
    expQ0.delete();
    #1;
    checkOutput("async count", 64'(getCount(0)), 64'(0));
    checkOutput("async enqRdy", 64'(enqRdy[0]), 64'(1));
    checkOutput("async deqRdy", 64'(deqRdy[0]), 64'(0));
    checkOutput("async first", 64'(firstOut[0]), 64'(0));
    checkOutput("async afull", 64'(afull[0]), 64'(0));
    enqEna[0] = 1'b0;
    @(posedge clk); #1;
    nRST = 1'b1;
    @(posedge clk); #1;
    applyStimulus(0, 1, 32'h55, 0, 0, 1);
    checkOutput("postrst first", 64'(firstOut[0]), 64'(32'h55));
    applyStimulus(0, 0, 32'h0, 1, 0, 0);
    checkOutput("postrst count", 64'(getCount(0)), 64'(0));

    // Every expected payload must have been delivered.
    @(posedge clk); #1;
    checkOutput("scoreboard0 empty", 64'(expQ0.size()), 64'(0));
    checkOutput("scoreboard1 empty", 64'(expQ1.size()), 64'(0));
    checkOutput("scoreboard2 empty", 64'(expQ2.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
